// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding, bus constants and address helper
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_DATA     = 3'd3,
      ST_DATA_ACK = 3'd4,
      ST_IGNORE   = 3'd5
   } i2c_state_t;

   // Level placed on SDA during the ninth clock: 0 acknowledges, 1 (released) refuses
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   // True when an address byte selects this target for a write transfer
   function automatic logic addr_write_hit(input logic [7:0] addr_byte,
                                           input logic [6:0] own_addr);
      return (addr_byte[7:1] == own_addr) && (addr_byte[0] == 1'b0);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // Pushes into a full buffer and pops from an empty one are dropped
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   // Head byte is visible without a pop; an empty buffer shows zero
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - write-only I2C target feeding a receive FIFO
import i2c_pkg::*;

module i2c_slave_rx #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic       rd_en,
   output logic [7:0] data_out,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       busy,
   output logic       overflow
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_d;
   logic       sda_d;
   logic [1:0] warm;
   logic       edges_ok;
   logic       scl_s;
   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;

   i2c_state_t state;
   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic [7:0] rx_byte;
   logic       byte_done;
   logic       sda_out;
   logic       push;

   // Open-drain output: only ever pulls low, otherwise floats
   assign i2c_sda = (sda_out == I2C_ACK) ? 1'b0 : 1'bz;

   // Bus inputs through two flops plus a delayed copy for edge detection;
   // warm masks edges until the pipeline holds real bus values after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
         warm     <= 2'd0;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl};
         sda_sync <= {sda_sync[0], i2c_sda};
         scl_d    <= scl_sync[1];
         sda_d    <= sda_sync[1];
         if (warm != 2'd3) begin
            warm <= warm + 2'd1;
         end
      end
   end

   assign edges_ok  = (warm == 2'd3);
   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = edges_ok && scl_s && !scl_d;
   assign scl_fall  = edges_ok && !scl_s && scl_d;
   assign start_det = edges_ok && scl_s && scl_d && sda_d && !sda_s;
   assign stop_det  = edges_ok && scl_s && scl_d && !sda_d && sda_s;

   assign rx_byte   = {shift, sda_s};
   assign byte_done = scl_rise && (bit_cnt == 3'd7);
   assign push      = (state == ST_DATA) && !start_det && !stop_det && byte_done && !fifo_full;

   // Protocol FSM; START and STOP override every state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         bit_cnt  <= 3'd0;
         shift    <= 7'd0;
         sda_out  <= I2C_NACK;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else if (start_det) begin
         state   <= ST_ADDR;
         bit_cnt <= 3'd0;
         shift   <= 7'd0;
         sda_out <= I2C_NACK;
      end else if (stop_det) begin
         state   <= ST_IDLE;
         sda_out <= I2C_NACK;
         busy    <= 1'b0;
      end else begin
         case (state)
            ST_ADDR, ST_DATA: begin
               if (scl_rise) begin
                  shift   <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 3'd1;
               end
               if (byte_done) begin
                  if (state == ST_ADDR) begin
                     if (addr_write_hit(rx_byte, SLAVE_ADDR)) begin
                        state <= ST_ADDR_ACK;
                        busy  <= 1'b1;
                     end else begin
                        state <= ST_IGNORE;
                        busy  <= 1'b0;
                     end
                  end else if (!fifo_full) begin
                     state <= ST_DATA_ACK;
                  end else begin
                     overflow <= 1'b1;
                     state    <= ST_IGNORE;
                  end
               end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
               // First fall after bit 8 starts the ACK, the next one ends it
               if (scl_fall) begin
                  if (sda_out == I2C_NACK) begin
                     sda_out <= I2C_ACK;
                  end else begin
                     sda_out <= I2C_NACK;
                     state   <= ST_DATA;
                     bit_cnt <= 3'd0;
                  end
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (push),
      .din   (rx_byte),
      .pop   (rd_en),
      .dout  (data_out),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - directed self-checking bench for i2c_slave_rx
module tb_i2c_slave_rx;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl;
   logic       m_sda;
   logic       rd_en;
   wire        sda_bus;
   logic [7:0] data_out;
   logic       fifo_empty;
   logic       fifo_full;
   logic       busy;
   logic       overflow;

   int tests = 0;
   int fails = 0;
   int drive_cnt = 0;

   pullup (sda_bus);
   assign sda_bus = m_sda ? 1'bz : 1'b0;

   always #5 clk = ~clk;

   i2c_slave_rx #(
      .SLAVE_ADDR (7'h50),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i2c_scl    (scl),
      .i2c_sda    (sda_bus),
      .rd_en      (rd_en),
      .data_out   (data_out),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .busy       (busy),
      .overflow   (overflow)
   );

   // Counts cycles where the target holds SDA low while the master releases it
   always @(negedge clk) begin
      #2;
      if (m_sda && sda_bus === 1'b0) drive_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; tick(Q);
      scl = 1'b1;   tick(Q);
      m_sda = 1'b0; tick(Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; tick(Q);
      scl = 1'b1;   tick(Q);
      m_sda = 1'b1; tick(Q);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b; tick(Q);
      scl = 1'b1; tick(2 * Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic get_ack(output logic a);
      m_sda = 1'b1; tick(Q);
      scl = 1'b1;   tick(Q);
      a = sda_bus;  tick(Q);
      scl = 1'b0;   tick(Q);
   endtask

   // pop_last raises rd_en in the cycle the target pushes this byte:
   // two sync flops plus the edge register put the push 3 edges after SCL rises
   task automatic write_byte(input logic [7:0] b, input logic pop_last, output logic a);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && pop_last) begin
            m_sda = b[0]; tick(Q);
            scl = 1'b1;   tick(2);
            rd_en = 1'b1; tick(1);
            rd_en = 1'b0; tick(2 * Q - 3);
            scl = 1'b0;   tick(Q);
         end else begin
            send_bit(b[i]);
         end
      end
      get_ack(a);
   endtask

   task automatic pop_byte(output logic [7:0] d);
      d = data_out;
      rd_en = 1'b1; tick(1);
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; scl = 1'b1; m_sda = 1'b1; rd_en = 1'b0;
      tick(3);
      tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got %h exp 00", data_out); end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
      tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", fifo_full); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL reset_sda got %b exp 1", sda_bus); end
      reset = 1'b0;
      tick(5);
   endtask

   task automatic test_basic_write();
      logic a;
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL basic_addr_ack got %b exp 0", a); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_mid got %b exp 1", busy); end
      write_byte(8'h3C, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL basic_data_ack got %b exp 0", a); end
      i2c_stop();
      tick(5);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", busy); end
      tests++; if (data_out !== 8'h3C) begin fails++; $display("FAIL basic_data_out got %h exp 3c", data_out); end
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL basic_empty got %b exp 0", fifo_empty); end
   endtask

   task automatic test_bad_address();
      logic a;
      logic [7:0] d;
      int d0;
      d0 = drive_cnt;
      i2c_start();
      write_byte(8'hA2, 1'b0, a);
      tests++; if (a !== 1'b1) begin fails++; $display("FAIL badaddr_nack got %b exp 1", a); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badaddr_busy got %b exp 0", busy); end
      write_byte(8'h77, 1'b0, a);
      tests++; if (a !== 1'b1) begin fails++; $display("FAIL badaddr_data_nack got %b exp 1", a); end
      i2c_stop();
      i2c_start();
      write_byte(8'hA1, 1'b0, a);
      tests++; if (a !== 1'b1) begin fails++; $display("FAIL read_nack got %b exp 1", a); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL read_busy got %b exp 0", busy); end
      i2c_stop();
      tick(5);
      tests++; if (drive_cnt !== d0) begin fails++; $display("FAIL badaddr_sda_driven got %0d exp %0d", drive_cnt, d0); end
      pop_byte(d);
      tests++; if (d !== 8'h3C) begin fails++; $display("FAIL badaddr_fifo got %h exp 3c", d); end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL badaddr_empty got %b exp 1", fifo_empty); end
   endtask

   task automatic test_overflow();
      logic a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL ovf_addr_ack got %b exp 0", a); end
      for (int k = 1; k <= 9; k++) begin
         write_byte(8'(k), 1'b0, a);
         tests++; if (a !== (k > 8)) begin fails++; $display("FAIL ovf_ack_%0d got %b exp %b", k, a, (k > 8)); end
      end
      i2c_stop();
      tick(5);
      tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ovf_busy got %b exp 0", busy); end
      for (int k = 1; k <= 8; k++) begin
         pop_byte(d);
         tests++; if (d !== 8'(k)) begin fails++; $display("FAIL ovf_pop_%0d got %h exp %h", k, d, 8'(k)); end
      end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL ovf_empty got %b exp 1", fifo_empty); end
      tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
   endtask

   task automatic test_repeated_start();
      logic a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL rs_addr1_ack got %b exp 0", a); end
      write_byte(8'h55, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL rs_data1_ack got %b exp 0", a); end
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL rs_addr2_ack got %b exp 0", a); end
      write_byte(8'h66, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL rs_data2_ack got %b exp 0", a); end
      i2c_stop();
      tick(5);
      pop_byte(d);
      tests++; if (d !== 8'h55) begin fails++; $display("FAIL rs_pop1 got %h exp 55", d); end
      pop_byte(d);
      tests++; if (d !== 8'h66) begin fails++; $display("FAIL rs_pop2 got %h exp 66", d); end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL rs_empty got %b exp 1", fifo_empty); end
   endtask

   task automatic test_back_to_back();
      logic a;
      logic [7:0] d;
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      write_byte(8'h11, 1'b0, a);
      write_byte(8'h22, 1'b0, a);
      write_byte(8'h33, 1'b0, a);
      tests++; if (data_out !== 8'h11) begin fails++; $display("FAIL b2b_head got %h exp 11", data_out); end
      write_byte(8'h44, 1'b1, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL b2b_ack got %b exp 0", a); end
      i2c_stop();
      tick(5);
      pop_byte(d);
      tests++; if (d !== 8'h22) begin fails++; $display("FAIL b2b_pop1 got %h exp 22", d); end
      pop_byte(d);
      tests++; if (d !== 8'h33) begin fails++; $display("FAIL b2b_pop2 got %h exp 33", d); end
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL b2b_not_empty got %b exp 0", fifo_empty); end
      pop_byte(d);
      tests++; if (d !== 8'h44) begin fails++; $display("FAIL b2b_pop3 got %h exp 44", d); end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got %b exp 1", fifo_empty); end
   endtask

   task automatic test_mid_reset();
      logic a;
      // Reset while the target is acknowledging its address
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
      m_sda = 1'b1; tick(Q);
      scl = 1'b1;   tick(Q);
      tests++; if (sda_bus !== 1'b0) begin fails++; $display("FAIL mr_ack_drive got %b exp 0", sda_bus); end
      #2 reset = 1'b1;
      #1;
      tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL mr_ack_release got %b exp 1", sda_bus); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mr_overflow got %b exp 0", overflow); end
      tick(Q);
      reset = 1'b0; tick(Q);
      scl = 1'b0;   tick(Q);
      i2c_stop();
      // Reset during bit 4 of a data byte
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      write_byte(8'h99, 1'b0, a);
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL mr_prefill got %b exp 0", fifo_empty); end
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      m_sda = 1'b1; tick(Q);
      scl = 1'b1;   tick(Q);
      #2 reset = 1'b1;
      #1;
      tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL mr_sda got %b exp 1", sda_bus); end
      tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL mr_data_out got %h exp 00", data_out); end
      tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL mr_empty got %b exp 1", fifo_empty); end
      tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL mr_full got %b exp 0", fifo_full); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mr_busy got %b exp 0", busy); end
      tick(Q);
      reset = 1'b0; tick(Q);
      scl = 1'b0;   tick(Q);
      i2c_stop();
      // Next full transaction must work normally
      i2c_start();
      write_byte(8'hA0, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL mr_after_addr got %b exp 0", a); end
      write_byte(8'hAB, 1'b0, a);
      tests++; if (a !== 1'b0) begin fails++; $display("FAIL mr_after_data got %b exp 0", a); end
      i2c_stop();
      tick(5);
      tests++; if (data_out !== 8'hAB) begin fails++; $display("FAIL mr_after_out got %h exp ab", data_out); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mr_after_busy got %b exp 0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_bad_address();
      test_overflow();
      test_repeated_start();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_slave_rx.md
I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this target responds to.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the receive buffer depth in bytes (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  system clock, at least 8x the SCL frequency.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i2c_scl  input  1  bus clock; the target never stretches SCL.
REQ-006 SHALL have port i2c_sda  inout  1  open-drain data line, driven only as 0 or high-Z.
REQ-007 SHALL have port rd_en  input  1  pops the head byte when fifo_empty=0.
REQ-008 SHALL have port data_out  output  8  head byte of the receive FIFO (first-word fall-through).
REQ-009 SHALL have port fifo_empty  output  1  receive FIFO holds no bytes.
REQ-010 SHALL have port fifo_full  output  1  receive FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port busy  output  1  high from an addressed START to the next STOP.
REQ-012 SHALL have port overflow  output  1  sticky flag: a data byte was NACKed because the FIFO was full.

Function
REQ-013 SHALL pass SCL and SDA through 2-flop synchronizers and detect edges from the synchronized values and their one-cycle-delayed copies.
REQ-014 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-015 SHALL sample SDA on each synchronized SCL rising edge, MSB first, using a 3-bit bit counter.
REQ-016 SHALL implement the states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE.
REQ-017 SHALL enter ADDR on a START from any state, including a repeated START, clearing the bit counter and shift register.
REQ-018 SHALL enter IDLE on a STOP from any state and release SDA in the same cycle.
REQ-019 ADDR: after the 8th bit, SHALL go to ADDR_ACK if addr[7:1]==SLAVE_ADDR and the R/W bit is 0, otherwise to IGNORE without driving SDA.
REQ-020 ADDR_ACK and DATA_ACK: SHALL pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge, then release it.
REQ-021 DATA: after the 8th bit, SHALL push the byte into the FIFO in the same clk cycle and ACK it if fifo_full=0.
REQ-022 DATA when the FIFO is full: SHALL drop the byte, leave SDA released (NACK), set overflow, and go to IGNORE.
REQ-023 SHALL return from DATA_ACK to DATA, so multi-byte writes continue indefinitely until STOP or START.
REQ-024 IGNORE: SHALL never drive SDA and SHALL leave only on START or STOP.
REQ-025 SHALL present a pushed byte on data_out with fifo_empty=0 one clk cycle after the push when the FIFO was empty.
REQ-026 SHALL accept a simultaneous push and pop, with the count unchanged; a pop while empty SHALL be ignored.
REQ-027 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and track the count with a log2(FIFO_DEPTH)+1-bit counter.
REQ-028 SHALL assert busy on entering ADDR_ACK and deassert it on STOP or on entering IGNORE from ADDR.

Reset
REQ-029 On reset, SHALL set state=IDLE, release SDA, and clear the bit counter, shift register, FIFO pointers and count.
REQ-030 On reset, SHALL drive data_out=8'h00, fifo_empty=1, fifo_full=0, busy=0 and overflow=0.
REQ-031 On a reset asserted mid-transfer, SHALL release SDA immediately and SHALL ignore the bus until the next START.

Structure
REQ-032 SHALL place the state encoding and the I2C_ACK=0 / I2C_NACK=1 constants in the shared package i2c_pkg, also used by the master.
REQ-033 SHALL instantiate one sub-module, sync_fifo (parameterised width 8, FIFO_DEPTH, first-word fall-through), holding the receive buffer.

Verification
REQ-034 Send START, 0xA0, 0x3C, STOP -> both bytes ACKed; data_out=0x3C; fifo_empty=0; busy high during the transfer, low after STOP.
REQ-035 Send START, 0xA2 (wrong address) or 0xA1 (read) -> SDA never driven; FIFO unchanged; busy=0.
REQ-036 Write 9 bytes 0x01..0x09 with no pops and FIFO_DEPTH=8 -> bytes 1-8 ACKed, byte 9 NACKed; overflow=1; fifo_full=1; pops return 0x01..0x08.
REQ-037 Send START, 0xA0, 0x55, repeated START, 0xA0, 0x66, STOP -> FIFO holds 0x55 then 0x66; all bytes ACKed.
REQ-038 Assert reset during bit 4 of a data byte -> SDA high-Z immediately; all outputs at reset values; the next full transaction succeeds.
REQ-039 With the FIFO holding 3 bytes, assert rd_en in the cycle a new byte is pushed -> count stays 3; ordering preserved.
